// File: rtl/fifo_stream_reader.sv
// Read-side controller for syn_fifo: pops words, absorbs the 1-cycle read latency and
// re-times them through a 2-entry skid buffer onto a valid/ready stream tagged with m_last.
// Optional word counter output enabled by defining FIFO_STREAM_CNT_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_NUM     = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_valid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_STREAM_CNT_EN
  ,
  output logic [31:0]           word_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST_CH = CNT_WIDTH'(CH_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] CH_ONE  = CNT_WIDTH'(1'b1);

  logic [1:0]            occ_r;
  logic                  inflight_r;
  logic [CNT_WIDTH-1:0]  ch_cnt_r;
  logic [DATA_WIDTH-1:0] buf_r [2];
  logic                  head_r;
  logic                  m_valid_r;
  logic                  m_last_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] m_data_r;

  logic                  pop_s;
  logic                  capture_s;
  logic [2:0]            credit_s;
  logic                  rd_en_s;
  logic                  tail_s;
  logic                  head_nxt_s;
  logic [1:0]            occ_nxt_s;
  logic [CNT_WIDTH-1:0]  ch_cnt_nxt_s;
  logic [DATA_WIDTH-1:0] m_data_nxt_s;

  // Credit check, buffer pointers and next-state values for the output registers
  always_comb begin
    pop_s      = m_valid_r & m_ready;
    capture_s  = fifo_valid & inflight_r;
    // Slots already committed (held or in flight) minus the one freed by this cycle's pop
    credit_s   = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    rd_en_s    = ~fifo_empty & ~flush & (credit_s < 3'd2);
    tail_s     = head_r ^ occ_r[0];
    head_nxt_s = head_r ^ pop_s;
    occ_nxt_s  = occ_r + {1'b0, capture_s} - {1'b0, pop_s};
    if (pop_s) begin
      if (ch_cnt_r == LAST_CH) begin
        ch_cnt_nxt_s = {CNT_WIDTH{1'b0}};
      end else begin
        ch_cnt_nxt_s = ch_cnt_r + CH_ONE;
      end
    end else begin
      ch_cnt_nxt_s = ch_cnt_r;
    end
    // A word landing in the slot that becomes head bypasses the buffer into m_data
    if (capture_s && (tail_s == head_nxt_s)) begin
      m_data_nxt_s = fifo_rd_data;
    end else begin
      m_data_nxt_s = buf_r[head_nxt_s];
    end
  end

  // Skid buffer state, channel counter and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      ch_cnt_r   <= {CNT_WIDTH{1'b0}};
      head_r     <= 1'b0;
      buf_r[0]   <= {DATA_WIDTH{1'b0}};
      buf_r[1]   <= {DATA_WIDTH{1'b0}};
      m_valid_r  <= 1'b0;
      m_last_r   <= 1'b0;
      busy_r     <= 1'b0;
      m_data_r   <= {DATA_WIDTH{1'b0}};
    end else if (flush) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      ch_cnt_r   <= {CNT_WIDTH{1'b0}};
      head_r     <= 1'b0;
      m_valid_r  <= 1'b0;
      m_last_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      occ_r      <= occ_nxt_s;
      inflight_r <= rd_en_s;
      ch_cnt_r   <= ch_cnt_nxt_s;
      head_r     <= head_nxt_s;
      if (capture_s) begin
        buf_r[tail_s] <= fifo_rd_data;
      end
      m_valid_r  <= (occ_nxt_s != 2'd0);
      m_last_r   <= (occ_nxt_s != 2'd0) & (ch_cnt_nxt_s == LAST_CH);
      busy_r     <= (occ_nxt_s != 2'd0) | rd_en_s;
      m_data_r   <= m_data_nxt_s;
    end
  end

`ifdef FIFO_STREAM_CNT_EN
  logic [31:0] word_cnt_r;

  // Free-running count of delivered words, wraps naturally at 2**32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_r <= 32'd0;
    end else if (flush) begin
      word_cnt_r <= 32'd0;
    end else if (pop_s) begin
      word_cnt_r <= word_cnt_r + 32'd1;
    end
  end

  assign word_cnt = word_cnt_r;
`endif

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign m_last     = m_last_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a behavioural FIFO feeds the DUT and a
// queue-based scoreboard checks word order, channel tagging, credit limit and flush.
module tb_fifo_stream_reader;
  localparam int DW = 16;
  localparam int CH = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = 16'h0000;
  logic          fifo_valid = 1'b0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
`ifdef FIFO_STREAM_CNT_EN
  logic [31:0]   word_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // upstream FIFO model
  logic [DW-1:0] mem [0:1023];
  logic [9:0]    wp = 10'd0;
  logic [9:0]    rp = 10'd0;
  logic          fifo_drop;
  int            rd_cnt = 0;

  // scoreboard
  logic [DW-1:0] exp_q [$];
  int            grp;

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);

  fifo_stream_reader #(.DATA_WIDTH(DW), .CH_NUM(CH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_valid(fifo_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
`ifdef FIFO_STREAM_CNT_EN
    , .word_cnt(word_cnt)
`endif
  );

  // one-cycle read latency FIFO
  always @(posedge clk) begin
    if (fifo_drop) begin
      rp         <= wp;
      fifo_valid <= 1'b0;
    end else begin
      fifo_valid <= fifo_rd_en && (rp != wp);
      if (fifo_rd_en && (rp != wp)) begin
        fifo_rd_data <= mem[rp];
        rp           <= rp + 10'd1;
        rd_cnt       <= rd_cnt + 1;
      end
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wp] = w;
    wp = wp + 10'd1;
    exp_q.push_back(w);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_drop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    fifo_drop = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    grp = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if (m_data !== 16'h0000 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: m_data=%h m_last=%b, expected 0000/0", m_data, m_last);
    end
`ifdef FIFO_STREAM_CNT_EN
    n_tests++;
    if (word_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: rd_en=%b m_valid=%b busy=%b, expected 0/0/0",
                 i, fifo_rd_en, m_valid, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream16;
    int first = -1;
    int last_i = -1;
    do_reset();
    m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) push(16'(k));
    for (int i = 1; i <= 60 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (m_valid) begin
        n_tests++;
        if (m_data !== exp_q[0] || m_last !== (grp == CH - 1)) begin
          n_fail++;
          $display("FAIL stream16 beat: data=%h last=%b expected data=%h last=%b",
                   m_data, m_last, exp_q[0], (grp == CH - 1));
        end
        if (first < 0) first = i;
        last_i = i;
        void'(exp_q.pop_front());
        grp = (grp + 1) % CH;
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || first != 2 || last_i - first != 15) begin
      n_fail++;
      $display("FAIL stream16 timing: left=%0d first=%0d span=%0d expected 0/2/15",
               exp_q.size(), first, last_i - first);
    end
  endtask

  task automatic test_backpressure;
    int rd_base;
    do_reset();
    m_ready = 1'b0;
    rd_base = rd_cnt;
    for (int k = 1; k <= 4; k++) push(16'(k));
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 16'h0001) begin
          n_fail++;
          $display("FAIL bp_hold cyc%0d: m_valid=%b m_data=%h expected 1/0001", i, m_valid, m_data);
        end
      end
    end
    n_tests++;
    if (rd_cnt - rd_base != 2 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_reads: reads=%0d rd_en=%b expected 2/0", rd_cnt - rd_base, fifo_rd_en);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
      if (m_valid) begin
        n_tests++;
        if (m_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL bp_drain: data=%h expected %h", m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end: left=%0d m_valid=%b expected 0/0", exp_q.size(), m_valid);
    end
  endtask

  task automatic test_toggle;
    int rd_base;
    int pops = 0;
    do_reset();
    rd_base = rd_cnt;
    for (int k = 0; k < 20; k++) push(16'($urandom));
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      m_ready = i[0];
      n_tests++;
      if ((rd_cnt - rd_base) - pops > 2) begin
        n_fail++;
        $display("FAIL toggle_credit: outstanding=%0d expected <=2", (rd_cnt - rd_base) - pops);
      end
      if (m_valid && m_ready) begin
        n_tests++;
        if (m_data !== exp_q[0] || m_last !== (grp == CH - 1)) begin
          n_fail++;
          $display("FAIL toggle_beat: data=%h last=%b expected %h/%b",
                   m_data, m_last, exp_q[0], (grp == CH - 1));
        end
        void'(exp_q.pop_front());
        grp = (grp + 1) % CH;
        pops++;
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL toggle_done: %0d words missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_flush;
    int rd_base;
    int pops = 0;
    int dropped;
    do_reset();
    rd_base = rd_cnt;
    m_ready = 1'b1;
    for (int k = 1; k <= 3; k++) push(16'h0C00 + 16'(k));
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (m_valid) begin
        void'(exp_q.pop_front());
        grp = (grp + 1) % CH;
        pops++;
      end
    end
    @(negedge clk);
    for (int k = 1; k <= 12; k++) push(16'h0B00 + 16'(k));
    #1;
    n_tests++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre_rd: rd_en=%b expected 1", fifo_rd_en);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_tests++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_rd_block: rd_en=%b expected 0", fifo_rd_en);
    end
    @(negedge clk);
    flush = 1'b0;
    n_tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: m_valid=%b busy=%b expected 0/0", m_valid, busy);
    end
`ifdef FIFO_STREAM_CNT_EN
    n_tests++;
    if (word_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_word_cnt: got %0d expected 0", word_cnt);
    end
`endif
    // everything read from the FIFO but not delivered is lost
    dropped = (rd_cnt - rd_base) - pops;
    n_tests++;
    if (dropped != 1) begin
      n_fail++;
      $display("FAIL flush_dropped: got %0d expected 1", dropped);
    end
    for (int d = 0; d < dropped && exp_q.size() > 0; d++) void'(exp_q.pop_front());
    grp = 0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (m_valid) begin
        n_tests++;
        if (m_data !== exp_q[0] || m_last !== (grp == CH - 1)) begin
          n_fail++;
          $display("FAIL flush_after: data=%h last=%b expected %h/%b",
                   m_data, m_last, exp_q[0], (grp == CH - 1));
        end
        void'(exp_q.pop_front());
        grp = (grp + 1) % CH;
      end
      @(negedge clk);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_done: %0d words missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_random;
    int rd_base;
    int pops = 0;
    int pushed = 0;
    do_reset();
    rd_base = rd_cnt;
    for (int i = 0; i < 600 && (pushed < 40 || exp_q.size() > 0); i++) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 40 && $urandom_range(0, 2) != 0) begin
        push(16'($urandom));
        pushed++;
      end
      n_tests++;
      if ((rd_cnt - rd_base) - pops > 2) begin
        n_fail++;
        $display("FAIL random_credit: outstanding=%0d expected <=2", (rd_cnt - rd_base) - pops);
      end
      if (m_valid && m_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_extra: data=%h expected no word", m_data);
        end else begin
          if (m_data !== exp_q[0] || m_last !== (grp == CH - 1)) begin
            n_fail++;
            $display("FAIL random_beat: data=%h last=%b expected %h/%b",
                     m_data, m_last, exp_q[0], (grp == CH - 1));
          end
          void'(exp_q.pop_front());
        end
        grp = (grp + 1) % CH;
        pops++;
      end
    end
    n_tests++;
    if (pushed != 40 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_done: pushed=%0d left=%0d expected 40/0", pushed, exp_q.size());
    end
  endtask

`ifdef FIFO_STREAM_CNT_EN
  task automatic test_word_cnt;
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 37; k++) push(16'($urandom));
    for (int i = 0; i < 120 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (m_valid) begin
        n_tests++;
        if (m_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL cnt_beat: data=%h expected %h", m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    n_tests++;
    if (word_cnt !== 32'd37) begin
      n_fail++;
      $display("FAIL cnt_total: got %0d expected 37", word_cnt);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++;
    if (word_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL cnt_flush: got %0d expected 0", word_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_drop = 1'b1;
    test_reset();
    test_stream16();
    test_backpressure();
    test_toggle();
    test_flush();
    test_random();
`ifdef FIFO_STREAM_CNT_EN
    test_word_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
